// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the integer register file write port from ALU and LSU.
// Optional macro WB_BYPASS_EN adds per-operand forwarding of the youngest queued value.
module wb_write_queue #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     AluValid,
  output logic                     AluReady,
  input  logic [ADDR_W-1:0]        AluAddr,
  input  logic [DATA_W-1:0]        AluData,
  input  logic                     LsuValid,
  output logic                     LsuReady,
  input  logic [ADDR_W-1:0]        LsuAddr,
  input  logic [DATA_W-1:0]        LsuData,
  input  logic                     WbHold,
  output logic                     RdWriteEnable,
  output logic [ADDR_W-1:0]        RdWriteAddr,
  output logic [DATA_W-1:0]        RdWriteData,
  input  logic [ADDR_W-1:0]        Rs1AddrIn,
  input  logic [ADDR_W-1:0]        Rs2AddrIn,
  output logic                     Rs1Pending,
  output logic                     Rs2Pending,
  output logic [$clog2(DEPTH):0]   Count
`ifdef WB_BYPASS_EN
  ,
  output logic                     Rs1FwdValid,
  output logic [DATA_W-1:0]        Rs1FwdData,
  output logic                     Rs2FwdValid,
  output logic [DATA_W-1:0]        Rs2FwdData
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [DEPTH-1:0]  validMem;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic              notFull;
  logic              lsuFire;
  logic              aluFire;
  logic              pushEn;
  logic              popEn;
  logic              notEmpty;
  logic [ADDR_W-1:0] inAddr;
  logic [DATA_W-1:0] inData;

  // Readies are held low while in reset so nothing is accepted before the queue is live.
  assign notFull  = Rst && (count < FULL_CNT);
  assign LsuReady = notFull;
  assign AluReady = notFull && !LsuValid;
  assign lsuFire  = LsuValid && LsuReady;
  assign aluFire  = AluValid && AluReady;
  assign inAddr   = lsuFire ? LsuAddr : AluAddr;
  assign inData   = lsuFire ? LsuData : AluData;
  assign pushEn   = (lsuFire || aluFire) && (inAddr != '0);

  assign notEmpty      = (count != '0);
  assign RdWriteEnable = notEmpty && !WbHold;
  assign RdWriteAddr   = notEmpty ? addrMem[rdPtr] : '0;
  assign RdWriteData   = notEmpty ? dataMem[rdPtr] : '0;
  assign popEn         = RdWriteEnable;
  assign Count         = count;

  // Push and pop never touch the same slot: pop needs non-empty, push needs non-full.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      validMem <= '0;
    end else begin
      if (popEn) begin
        rdPtr           <= rdPtr + 1'b1;
        validMem[rdPtr] <= 1'b0;
      end
      if (pushEn) begin
        wrPtr           <= wrPtr + 1'b1;
        validMem[wrPtr] <= 1'b1;
      end
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (pushEn) begin
      addrMem[wrPtr] <= inAddr;
      dataMem[wrPtr] <= inData;
    end
  end

  always_comb begin
    Rs1Pending = 1'b0;
    Rs2Pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (validMem[i] && (addrMem[i] == Rs1AddrIn)) Rs1Pending = 1'b1;
      if (validMem[i] && (addrMem[i] == Rs2AddrIn)) Rs2Pending = 1'b1;
    end
    if (Rs1AddrIn == '0) Rs1Pending = 1'b0;
    if (Rs2AddrIn == '0) Rs2Pending = 1'b0;
  end

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] fwdIdx;

  // Valid entries are contiguous from rdPtr, so walking oldest to youngest lets the last match win.
  always_comb begin
    fwdIdx     = '0;
    Rs1FwdData = '0;
    Rs2FwdData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwdIdx = rdPtr + PTR_W'(i);
      if (validMem[fwdIdx] && (Rs1AddrIn != '0) && (addrMem[fwdIdx] == Rs1AddrIn))
        Rs1FwdData = dataMem[fwdIdx];
      if (validMem[fwdIdx] && (Rs2AddrIn != '0) && (addrMem[fwdIdx] == Rs2AddrIn))
        Rs2FwdData = dataMem[fwdIdx];
    end
  end

  assign Rs1FwdValid = Rs1Pending;
  assign Rs2FwdValid = Rs2Pending;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed scenarios plus random traffic against a queue model.
// Define WB_BYPASS_EN to also check the forwarding outputs.
module tb_wb_write_queue;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              AluValid, AluReady, LsuValid, LsuReady, WbHold;
  logic [ADDR_W-1:0] AluAddr, LsuAddr, RdWriteAddr, Rs1AddrIn, Rs2AddrIn;
  logic [DATA_W-1:0] AluData, LsuData, RdWriteData;
  logic              RdWriteEnable, Rs1Pending, Rs2Pending;
  logic [$clog2(DEPTH):0] Count;
`ifdef WB_BYPASS_EN
  logic              Rs1FwdValid, Rs2FwdValid;
  logic [DATA_W-1:0] Rs1FwdData, Rs2FwdData;
`endif

  wb_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .AluValid(AluValid), .AluReady(AluReady), .AluAddr(AluAddr), .AluData(AluData),
    .LsuValid(LsuValid), .LsuReady(LsuReady), .LsuAddr(LsuAddr), .LsuData(LsuData),
    .WbHold(WbHold),
    .RdWriteEnable(RdWriteEnable), .RdWriteAddr(RdWriteAddr), .RdWriteData(RdWriteData),
    .Rs1AddrIn(Rs1AddrIn), .Rs2AddrIn(Rs2AddrIn),
    .Rs1Pending(Rs1Pending), .Rs2Pending(Rs2Pending),
    .Count(Count)
`ifdef WB_BYPASS_EN
    ,
    .Rs1FwdValid(Rs1FwdValid), .Rs1FwdData(Rs1FwdData),
    .Rs2FwdValid(Rs2FwdValid), .Rs2FwdData(Rs2FwdData)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t      q[$];
  int          nChecks = 0;
  int          nErrors = 0;
  logic [63:0] lastEnq [32];
  logic [63:0] obsRf   [32];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic expPending(input logic [ADDR_W-1:0] a);
    expPending = 1'b0;
    if (a != 0)
      foreach (q[k]) if (q[k].addr == a) expPending = 1'b1;
  endfunction

  function automatic logic [63:0] expFwd(input logic [ADDR_W-1:0] a);
    expFwd = '0;
    if (a != 0)
      foreach (q[k]) if (q[k].addr == a) expFwd = q[k].data;
  endfunction

  // One cycle: drive inputs after the falling edge, check outputs, then apply the edge to the model.
  task automatic applyStimulus(input logic aluV, input logic [ADDR_W-1:0] aluA, input logic [63:0] aluD,
                               input logic lsuV, input logic [ADDR_W-1:0] lsuA, input logic [63:0] lsuD,
                               input logic hold, input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                               output bit acc);
    bit full, lsuAcc, aluAcc, expWe;
    entry_t e;
    AluValid = aluV; AluAddr = aluA; AluData = aluD;
    LsuValid = lsuV; LsuAddr = lsuA; LsuData = lsuD;
    WbHold = hold; Rs1AddrIn = r1; Rs2AddrIn = r2;
    #1;
    full   = (q.size() >= DEPTH);
    lsuAcc = lsuV && !full;
    aluAcc = aluV && !full && !lsuV;
    expWe  = (q.size() != 0) && !hold;
    acc    = lsuAcc || aluAcc;
    checkOutput("LsuReady", 64'(LsuReady), 64'(!full));
    checkOutput("AluReady", 64'(AluReady), 64'(!full && !lsuV));
    checkOutput("Count", 64'(Count), 64'(q.size()));
    checkOutput("RdWriteEnable", 64'(RdWriteEnable), 64'(expWe));
    if (q.size() != 0) begin
      checkOutput("RdWriteAddr", 64'(RdWriteAddr), 64'(q[0].addr));
      checkOutput("RdWriteData", RdWriteData, q[0].data);
    end else begin
      checkOutput("RdWriteAddr", 64'(RdWriteAddr), 64'd0);
      checkOutput("RdWriteData", RdWriteData, 64'd0);
    end
    checkOutput("Rs1Pending", 64'(Rs1Pending), 64'(expPending(r1)));
    checkOutput("Rs2Pending", 64'(Rs2Pending), 64'(expPending(r2)));
`ifdef WB_BYPASS_EN
    checkOutput("Rs1FwdValid", 64'(Rs1FwdValid), 64'(expPending(r1)));
    checkOutput("Rs2FwdValid", 64'(Rs2FwdValid), 64'(expPending(r2)));
    checkOutput("Rs1FwdData", Rs1FwdData, expFwd(r1));
    checkOutput("Rs2FwdData", Rs2FwdData, expFwd(r2));
`endif
    if (RdWriteEnable === 1'b1) obsRf[RdWriteAddr] = RdWriteData;
    @(posedge Clk);
    if (expWe) void'(q.pop_front());
    if (lsuAcc && lsuA != 0) begin
      e.addr = lsuA; e.data = lsuD; q.push_back(e); lastEnq[lsuA] = lsuD;
    end else if (aluAcc && aluA != 0) begin
      e.addr = aluA; e.data = aluD; q.push_back(e); lastEnq[aluA] = aluD;
    end
    @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int tries;
    foreach (lastEnq[k]) begin lastEnq[k] = '0; obsRf[k] = '0; end
    Rst = 1'b0; WbHold = 1'b0;
    AluValid = 1'b1; AluAddr = 5'd3; AluData = 64'hAB;
    LsuValid = 1'b0; LsuAddr = '0; LsuData = '0;
    Rs1AddrIn = 5'd3; Rs2AddrIn = 5'd0;
    @(negedge Clk); @(negedge Clk);
    $display("[TB] reset state");
    checkOutput("rst_AluReady", 64'(AluReady), 64'd0);
    checkOutput("rst_LsuReady", 64'(LsuReady), 64'd0);
    checkOutput("rst_Count", 64'(Count), 64'd0);
    checkOutput("rst_RdWriteEnable", 64'(RdWriteEnable), 64'd0);
    checkOutput("rst_RdWriteAddr", 64'(RdWriteAddr), 64'd0);
    checkOutput("rst_RdWriteData", RdWriteData, 64'd0);
    checkOutput("rst_Rs1Pending", 64'(Rs1Pending), 64'd0);
    Rst = 1'b1;

    $display("[TB] single write");
    applyStimulus(1, 5'd3, 64'hAB, 0, 0, 0, 0, 5'd3, 5'd4, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd4, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd4, acc);

    $display("[TB] LSU priority");
    applyStimulus(1, 5'd6, 64'h22, 1, 5'd5, 64'h11, 0, 5'd5, 5'd6, acc);
    applyStimulus(1, 5'd6, 64'h22, 0, 0, 0, 0, 5'd5, 5'd6, acc);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd6, acc);
    checkOutput("prio_x5", obsRf[5], 64'h11);
    checkOutput("prio_x6", obsRf[6], 64'h22);

    $display("[TB] full and hold");
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 5'(10 + i), 64'(256 + i), 0, 0, 0, 1, 5'd12, 5'd13, acc);
    applyStimulus(1, 5'd14, 64'h999, 0, 0, 0, 1, 5'd10, 5'd14, acc);
    applyStimulus(1, 5'd14, 64'h999, 0, 0, 0, 0, 5'd10, 5'd14, acc);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd13, 5'd14, acc);
    checkOutput("full_x13", obsRf[13], 64'd259);

    $display("[TB] x0 drop");
    applyStimulus(1, 5'd0, 64'hFF, 0, 0, 0, 0, 5'd0, 5'd0, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, acc);
    checkOutput("x0_rf", obsRf[0], 64'd0);

    $display("[TB] wrap and duplicates");
    for (int i = 0; i < 10; i++) begin
      acc = 0; tries = 0;
      while (!acc && tries < 50) begin
        applyStimulus(1, (i % 2 == 0) ? 5'd7 : 5'd8, 64'(i), 0, 0, 0,
                      1'($urandom_range(0, 1)), 5'd7, 5'd8, acc);
        tries++;
      end
      checkOutput("wrap_accept", 64'(acc), 64'd1);
    end
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd8, acc);
    checkOutput("wrap_x7", obsRf[7], 64'd8);
    checkOutput("wrap_x8", obsRf[8], 64'd9);

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++)
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                    ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, acc);
    for (int a = 1; a < 8; a++) checkOutput($sformatf("rand_rf_x%0d", a), obsRf[a], lastEnq[a]);

    $display("[TB] async reset");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 5'(20 + i), 64'(4096 + i), 0, 0, 0, 1, 5'd20, 5'd21, acc);
    AluValid = 1'b0; WbHold = 1'b0; Rs1AddrIn = 5'd20; Rs2AddrIn = 5'd22;
    #2;
    Rst = 1'b0;
    #1;
    checkOutput("arst_Count", 64'(Count), 64'd0);
    checkOutput("arst_RdWriteEnable", 64'(RdWriteEnable), 64'd0);
    checkOutput("arst_RdWriteAddr", 64'(RdWriteAddr), 64'd0);
    checkOutput("arst_RdWriteData", RdWriteData, 64'd0);
    checkOutput("arst_AluReady", 64'(AluReady), 64'd0);
    checkOutput("arst_Rs1Pending", 64'(Rs1Pending), 64'd0);
    checkOutput("arst_Rs2Pending", 64'(Rs2Pending), 64'd0);
    q.delete();
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd20, 5'd21, acc);
    checkOutput("arst_no_stale_x20", obsRf[20], 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
